// File: rtl/mike_cache_control_if.sv
// mike_cache_control_if: datapath select types and the controller's CPU / pmem / array bus
// master: CPU + datapath side (drives requests, tag status, pmem_resp)
// slave : controller side (drives mem_resp, pmem requests, array strobes, selects, counters)
package mike_cache_types;
    typedef enum logic [1:0] {zero_enable, byte_enable, f_enable} bytemux_sel_t;
    typedef enum logic [1:0] {cpu, cache_way0, cache_way1} addrmux_sel_t;
    typedef enum logic {cpu_data, pmem_data} datainmux_sel_t;
    typedef enum logic {dataout_way0, dataout_way1} dataoutmux_sel_t;
endpackage

interface mike_cache_control_if #(parameter int CNT_W = 16);
    import mike_cache_types::*;
    logic mem_read, mem_write, mem_resp;
    logic pmem_read, pmem_write, pmem_resp;
    logic hit_0, hit_1, hit, dirty_set, lru_out;
    logic load_tag_0, load_tag_1, load_valid_0, load_valid_1, load_dirty_0, load_dirty_1, lru_load;
    logic valid_way0_in, valid_way1_in, dirty_way0_in, dirty_way1_in, lru_in;
    datainmux_sel_t datainmux_way0_sel, datainmux_way1_sel;
    dataoutmux_sel_t dataoutmux_sel;
    bytemux_sel_t bytemux_way0_sel, bytemux_way1_sel;
    addrmux_sel_t addressmuxout_sel;
    logic [CNT_W-1:0] hit_count, miss_count;
    modport master (
        output mem_read, mem_write, pmem_resp, hit_0, hit_1, hit, dirty_set, lru_out,
        input mem_resp, pmem_read, pmem_write,
        input load_tag_0, load_tag_1, load_valid_0, load_valid_1, load_dirty_0, load_dirty_1, lru_load,
        input valid_way0_in, valid_way1_in, dirty_way0_in, dirty_way1_in, lru_in,
        input datainmux_way0_sel, datainmux_way1_sel, dataoutmux_sel,
        input bytemux_way0_sel, bytemux_way1_sel, addressmuxout_sel, hit_count, miss_count
    );
    modport slave (
        input mem_read, mem_write, pmem_resp, hit_0, hit_1, hit, dirty_set, lru_out,
        output mem_resp, pmem_read, pmem_write,
        output load_tag_0, load_tag_1, load_valid_0, load_valid_1, load_dirty_0, load_dirty_1, lru_load,
        output valid_way0_in, valid_way1_in, dirty_way0_in, dirty_way1_in, lru_in,
        output datainmux_way0_sel, datainmux_way1_sel, dataoutmux_sel,
        output bytemux_way0_sel, bytemux_way1_sel, addressmuxout_sel, hit_count, miss_count
    );
endinterface

// File: rtl/mike_cache_control.sv
// mike_cache_control: two-way cache controller FSM (IDLE/CHECK/WRITEBACK/FILL) with hit/miss counters
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of mike_cache_control_if (CPU handshake, pmem handshake, array strobes, selects, counters)
module mike_cache_control
    import mike_cache_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    mike_cache_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
    state_t state;
    logic refill;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
    logic way1, chk_hit, wr_hit, wb, wb_done, fl, fl_done;
    // way0 wins when both ways report a match
    assign way1    = bus.hit_1 & ~bus.hit_0;
    // every output decode is masked by rst so nothing fires while reset is held
    assign chk_hit = ~rst & (state == CHECK) & bus.hit;
    assign wr_hit  = chk_hit & bus.mem_write;
    assign wb      = ~rst & (state == WRITEBACK);
    assign wb_done = wb & bus.pmem_resp;
    assign fl      = ~rst & (state == FILL);
    assign fl_done = fl & bus.pmem_resp;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            refill   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= (bus.mem_read | bus.mem_write) ? CHECK : IDLE;
                CHECK: begin
                    // the re-check after a fill belongs to an already counted miss
                    if (!refill && bus.hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    if (!refill && !bus.hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                    refill <= 1'b0;
                    state  <= bus.hit ? IDLE : bus.dirty_set ? WRITEBACK : FILL;
                end
                WRITEBACK: state <= bus.pmem_resp ? FILL : WRITEBACK;
                FILL: begin
                    refill <= bus.pmem_resp;
                    state  <= bus.pmem_resp ? CHECK : FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.mem_resp      = chk_hit;
    assign bus.pmem_write    = wb;
    assign bus.pmem_read     = fl;
    assign bus.load_tag_0    = fl_done & ~bus.lru_out;
    assign bus.load_tag_1    = fl_done & bus.lru_out;
    assign bus.load_valid_0  = fl_done & ~bus.lru_out;
    assign bus.load_valid_1  = fl_done & bus.lru_out;
    assign bus.valid_way0_in = fl_done & ~bus.lru_out;
    assign bus.valid_way1_in = fl_done & bus.lru_out;
    // victim dirty bit is cleared both after writeback and after fill
    assign bus.load_dirty_0  = (wr_hit & ~way1) | ((wb_done | fl_done) & ~bus.lru_out);
    assign bus.load_dirty_1  = (wr_hit & way1) | ((wb_done | fl_done) & bus.lru_out);
    assign bus.dirty_way0_in = wr_hit & ~way1;
    assign bus.dirty_way1_in = wr_hit & way1;
    assign bus.lru_load      = chk_hit;
    assign bus.lru_in        = chk_hit & ~way1;
    assign bus.bytemux_way0_sel   = (wr_hit & ~way1) ? byte_enable : (fl_done & ~bus.lru_out) ? f_enable : zero_enable;
    assign bus.bytemux_way1_sel   = (wr_hit & way1) ? byte_enable : (fl_done & bus.lru_out) ? f_enable : zero_enable;
    assign bus.datainmux_way0_sel = (fl_done & ~bus.lru_out) ? pmem_data : cpu_data;
    assign bus.datainmux_way1_sel = (fl_done & bus.lru_out) ? pmem_data : cpu_data;
    assign bus.dataoutmux_sel     = wb ? (bus.lru_out ? dataout_way1 : dataout_way0) :
                                    (chk_hit & way1) ? dataout_way1 : dataout_way0;
    assign bus.addressmuxout_sel  = wb ? (bus.lru_out ? cache_way1 : cache_way0) : cpu;
    assign bus.hit_count  = rst ? '0 : hit_cnt;
    assign bus.miss_count = rst ? '0 : miss_cnt;
endmodule

// File: tb/tb_mike_cache_control.sv
// tb_mike_cache_control: directed checks of mike_cache_control; a 3-bit-counter twin exercises saturation
module tb_mike_cache_control;
    import mike_cache_types::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mike_cache_control_if #(.CNT_W(16)) bus ();
    mike_cache_control_if #(.CNT_W(3)) bus_s ();
    mike_cache_control #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    mike_cache_control #(.CNT_W(3)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    assign bus_s.mem_read  = bus.mem_read;
    assign bus_s.mem_write = bus.mem_write;
    assign bus_s.pmem_resp = bus.pmem_resp;
    assign bus_s.hit_0     = bus.hit_0;
    assign bus_s.hit_1     = bus.hit_1;
    assign bus_s.hit       = bus.hit;
    assign bus_s.dirty_set = bus.dirty_set;
    assign bus_s.lru_out   = bus.lru_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0;
        bus.hit_0 = 0; bus.hit_1 = 0; bus.hit = 0; bus.dirty_set = 0; bus.lru_out = 0;
    endtask

    task automatic miss_quick;
        bus.mem_read = 1; bus.hit = 0; bus.hit_0 = 0;
        tick;
        tick;
        bus.pmem_resp = 1;
        tick;
        bus.pmem_resp = 0; bus.hit = 1; bus.hit_0 = 1;
        tick;
        clear;
    endtask

    task automatic hit_quick;
        bus.mem_read = 1; bus.hit = 1; bus.hit_0 = 1;
        tick;
        tick;
        clear;
    endtask

    initial begin
        clear;
        bus.mem_read = 1; bus.hit = 1; bus.hit_0 = 1;
        tick;
        tick;
        @(negedge clk);
        chk("rst mem_resp", bus.mem_resp, 0);
        chk("rst pmem_read", bus.pmem_read, 0);
        chk("rst pmem_write", bus.pmem_write, 0);
        chk("rst lru_load", bus.lru_load, 0);
        chk("rst hit_count", bus.hit_count, 0);
        chk("rst miss_count", bus.miss_count, 0);
        tick;
        rst = 0;
        clear;
        @(negedge clk);
        chk("idle addrmux", bus.addressmuxout_sel, cpu);
        chk("idle bytemux0", bus.bytemux_way0_sel, zero_enable);
        chk("idle dataoutmux", bus.dataoutmux_sel, dataout_way0);
        // read miss, clean victim way0, pmem_resp five cycles into FILL
        tick;
        bus.mem_read = 1;
        @(negedge clk);
        chk("t1 c0 mem_resp", bus.mem_resp, 0);
        tick;
        @(negedge clk);
        chk("t1 c1 mem_resp", bus.mem_resp, 0);
        chk("t1 c1 pmem_read", bus.pmem_read, 0);
        tick;
        @(negedge clk);
        chk("t1 fill pmem_read", bus.pmem_read, 1);
        chk("t1 fill pmem_write", bus.pmem_write, 0);
        chk("t1 fill addrmux", bus.addressmuxout_sel, cpu);
        chk("t1 miss_count", bus.miss_count, 1);
        repeat (4) tick;
        @(negedge clk);
        chk("t1 wait load_tag_0", bus.load_tag_0, 0);
        tick;
        bus.pmem_resp = 1;
        @(negedge clk);
        chk("t1 load_tag_0", bus.load_tag_0, 1);
        chk("t1 load_valid_0", bus.load_valid_0, 1);
        chk("t1 valid_way0_in", bus.valid_way0_in, 1);
        chk("t1 load_dirty_0", bus.load_dirty_0, 1);
        chk("t1 dirty_way0_in", bus.dirty_way0_in, 0);
        chk("t1 bytemux0", bus.bytemux_way0_sel, f_enable);
        chk("t1 datainmux0", bus.datainmux_way0_sel, pmem_data);
        chk("t1 load_tag_1", bus.load_tag_1, 0);
        tick;
        bus.pmem_resp = 0; bus.hit = 1; bus.hit_0 = 1;
        @(negedge clk);
        chk("t1 c8 mem_resp", bus.mem_resp, 1);
        chk("t1 c8 pmem_read", bus.pmem_read, 0);
        chk("t1 c8 lru_load", bus.lru_load, 1);
        chk("t1 c8 lru_in", bus.lru_in, 1);
        chk("t1 c8 load_tag_0", bus.load_tag_0, 0);
        tick;
        clear;
        @(negedge clk);
        chk("t1 end mem_resp", bus.mem_resp, 0);
        chk("t1 end hit_count", bus.hit_count, 0);
        chk("t1 end miss_count", bus.miss_count, 1);
        // write hit on way1
        tick;
        bus.mem_write = 1; bus.hit = 1; bus.hit_1 = 1;
        @(negedge clk);
        chk("t2 idle mem_resp", bus.mem_resp, 0);
        tick;
        @(negedge clk);
        chk("t2 mem_resp", bus.mem_resp, 1);
        chk("t2 bytemux1", bus.bytemux_way1_sel, byte_enable);
        chk("t2 bytemux0", bus.bytemux_way0_sel, zero_enable);
        chk("t2 datainmux1", bus.datainmux_way1_sel, cpu_data);
        chk("t2 load_dirty_1", bus.load_dirty_1, 1);
        chk("t2 dirty_way1_in", bus.dirty_way1_in, 1);
        chk("t2 load_dirty_0", bus.load_dirty_0, 0);
        chk("t2 lru_load", bus.lru_load, 1);
        chk("t2 lru_in", bus.lru_in, 0);
        tick;
        clear;
        @(negedge clk);
        chk("t2 hit_count", bus.hit_count, 1);
        chk("t2 mem_resp low", bus.mem_resp, 0);
        // read miss, dirty victim way1
        tick;
        bus.mem_read = 1; bus.lru_out = 1; bus.dirty_set = 1;
        tick;
        @(negedge clk);
        chk("t3 check pmem_write", bus.pmem_write, 0);
        tick;
        @(negedge clk);
        chk("t3 wb pmem_write", bus.pmem_write, 1);
        chk("t3 wb pmem_read", bus.pmem_read, 0);
        chk("t3 wb addrmux", bus.addressmuxout_sel, cache_way1);
        chk("t3 wb dataoutmux", bus.dataoutmux_sel, dataout_way1);
        chk("t3 wb load_dirty_1", bus.load_dirty_1, 0);
        tick;
        bus.pmem_resp = 1;
        @(negedge clk);
        chk("t3 wb done load_dirty_1", bus.load_dirty_1, 1);
        chk("t3 wb done dirty_way1_in", bus.dirty_way1_in, 0);
        chk("t3 wb done overlap", bus.pmem_read & bus.pmem_write, 0);
        chk("t3 wb done load_tag_1", bus.load_tag_1, 0);
        tick;
        bus.pmem_resp = 0; bus.dirty_set = 0;
        @(negedge clk);
        chk("t3 fill pmem_write", bus.pmem_write, 0);
        chk("t3 fill pmem_read", bus.pmem_read, 1);
        chk("t3 fill addrmux", bus.addressmuxout_sel, cpu);
        tick;
        bus.pmem_resp = 1;
        @(negedge clk);
        chk("t3 load_tag_1", bus.load_tag_1, 1);
        chk("t3 load_valid_1", bus.load_valid_1, 1);
        chk("t3 valid_way1_in", bus.valid_way1_in, 1);
        chk("t3 load_dirty_1", bus.load_dirty_1, 1);
        chk("t3 bytemux1", bus.bytemux_way1_sel, f_enable);
        chk("t3 datainmux1", bus.datainmux_way1_sel, pmem_data);
        chk("t3 load_tag_0", bus.load_tag_0, 0);
        chk("t3 fill overlap", bus.pmem_read & bus.pmem_write, 0);
        tick;
        bus.pmem_resp = 0; bus.hit = 1; bus.hit_1 = 1;
        @(negedge clk);
        chk("t3 mem_resp", bus.mem_resp, 1);
        chk("t3 pmem_read drop", bus.pmem_read, 0);
        chk("t3 dataoutmux", bus.dataoutmux_sel, dataout_way1);
        tick;
        clear;
        @(negedge clk);
        chk("t3 miss_count", bus.miss_count, 2);
        chk("t3 hit_count", bus.hit_count, 1);
        // back-to-back hits with a stray pmem_resp held high
        tick;
        bus.mem_read = 1; bus.hit = 1; bus.hit_1 = 1; bus.pmem_resp = 1;
        @(negedge clk);
        chk("t4 idle strobes", bus.load_tag_0 | bus.load_tag_1 | bus.load_dirty_0 | bus.load_dirty_1, 0);
        tick;
        @(negedge clk);
        chk("t4 r1 mem_resp", bus.mem_resp, 1);
        chk("t4 r1 dataoutmux", bus.dataoutmux_sel, dataout_way1);
        chk("t4 r1 lru_in", bus.lru_in, 0);
        chk("t4 r1 load_dirty_1", bus.load_dirty_1, 0);
        chk("t4 r1 load_tag_1", bus.load_tag_1, 0);
        tick;
        bus.hit_0 = 1;
        @(negedge clk);
        chk("t4 gap mem_resp", bus.mem_resp, 0);
        tick;
        @(negedge clk);
        chk("t4 r2 mem_resp", bus.mem_resp, 1);
        chk("t4 r2 dataoutmux", bus.dataoutmux_sel, dataout_way0);
        chk("t4 r2 lru_in", bus.lru_in, 1);
        tick;
        bus.mem_write = 1; bus.hit_1 = 0;
        @(negedge clk);
        chk("t4 gap2 mem_resp", bus.mem_resp, 0);
        tick;
        @(negedge clk);
        chk("t4 rw load_dirty_0", bus.load_dirty_0, 1);
        chk("t4 rw dirty_way0_in", bus.dirty_way0_in, 1);
        chk("t4 rw bytemux0", bus.bytemux_way0_sel, byte_enable);
        chk("t4 rw bytemux1", bus.bytemux_way1_sel, zero_enable);
        chk("t4 rw load_dirty_1", bus.load_dirty_1, 0);
        tick;
        clear;
        @(negedge clk);
        chk("t4 hit_count", bus.hit_count, 4);
        // saturation on the 3-bit twin
        repeat (6) miss_quick;
        @(negedge clk);
        chk("t5 miss_count", bus.miss_count, 8);
        chk("t5 small miss sat", bus_s.miss_count, 7);
        repeat (4) hit_quick;
        @(negedge clk);
        chk("t5 hit_count", bus.hit_count, 8);
        chk("t5 small hit sat", bus_s.hit_count, 7);
        // reset in the third FILL cycle, then a stale pmem_resp
        bus.mem_read = 1;
        tick;
        tick;
        tick;
        @(negedge clk);
        chk("t6 fill pmem_read", bus.pmem_read, 1);
        chk("t6 miss_count", bus.miss_count, 9);
        tick;
        rst = 1;
        @(negedge clk);
        chk("t6 rst pmem_read", bus.pmem_read, 0);
        chk("t6 rst mem_resp", bus.mem_resp, 0);
        chk("t6 rst miss_count", bus.miss_count, 0);
        chk("t6 rst hit_count", bus.hit_count, 0);
        tick;
        rst = 0;
        clear;
        bus.pmem_resp = 1;
        @(negedge clk);
        chk("t6 stale strobes", bus.load_tag_0 | bus.load_valid_0 | bus.load_dirty_0 | bus.load_tag_1, 0);
        chk("t6 stale pmem_read", bus.pmem_read, 0);
        chk("t6 after miss_count", bus.miss_count, 0);
        tick;
        bus.pmem_resp = 0; bus.mem_read = 1; bus.hit = 1; bus.hit_0 = 1;
        @(negedge clk);
        chk("t6 idle mem_resp", bus.mem_resp, 0);
        tick;
        @(negedge clk);
        chk("t6 mem_resp", bus.mem_resp, 1);
        tick;
        clear;
        @(negedge clk);
        chk("t6 hit_count", bus.hit_count, 1);
        chk("t6 small hit_count", bus_s.hit_count, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
